// File: rtl/digit_sequencer_if.sv
// Control and renderer-facing signals of the digit sequencer.
// The master side drives the user controls and vSync; the slave side is the sequencer.
interface digit_sequencer_if;
  logic       vSync;
  logic       run_en;
  logic       step;
  logic       load;
  logic [3:0] load_val;
  logic [3:0] digit;
  logic       running;
  logic       frame_tick;
  logic       pending;

  modport master (
    output vSync, run_en, step, load, load_val,
    input  digit, running, frame_tick, pending
  );

  modport slave (
    input  vSync, run_en, step, load, load_val,
    output digit, running, frame_tick, pending
  );
endinterface

// File: rtl/digit_sequencer.sv
// Chooses the digit shown by the renderer. Changes happen only at frame start (vSync fall),
// either from a latched load/step request or from the RUN-mode frame counter.
module digit_sequencer #(
  parameter int FRAMES_PER_STEP = 60,
  parameter int MAX_DIGIT       = 9
) (
  input  logic              pix_clk,
  input  logic              reset,
  digit_sequencer_if.slave  bus
);

  localparam int CNT_W = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAMES_PER_STEP - 1);
  localparam logic [3:0]       MAX_D    = 4'(MAX_DIGIT);

  typedef enum logic {PAUSE = 1'b0, RUN = 1'b1} state_t;

  function automatic logic [3:0] clamp_digit(input logic [3:0] v);
    return (v > MAX_D) ? MAX_D : v;
  endfunction

  function automatic logic [3:0] wrap_inc(input logic [3:0] v);
    return (v == MAX_D) ? 4'd0 : v + 4'd1;
  endfunction

  state_t           state_q, state_d;
  logic             vsync_q;
  logic             armed_q;
  logic             tick_q;
  logic [3:0]       digit_q, digit_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             load_pend_q, load_pend_d;
  logic             step_pend_q, step_pend_d;
  logic [3:0]       ld_val_q, ld_val_d;

  logic             fall;
  logic             load_now;
  logic             step_now;
  logic [3:0]       ld_now;

  // armed_q keeps a vSync held low across reset release from looking like an edge.
  assign fall     = armed_q & vsync_q & ~bus.vSync;
  assign load_now = load_pend_q | bus.load;
  assign ld_now   = bus.load ? clamp_digit(bus.load_val) : ld_val_q;
  assign step_now = step_pend_q | (bus.step & (state_q == PAUSE));

  always_comb begin
    state_d     = bus.run_en ? RUN : PAUSE;
    digit_d     = digit_q;
    cnt_d       = cnt_q;
    load_pend_d = load_now;
    ld_val_d    = ld_now;
    step_pend_d = step_now;
    if (fall) begin
      if (load_now) begin
        digit_d     = ld_now;
        cnt_d       = '0;
        load_pend_d = 1'b0;
        step_pend_d = 1'b0;
      end else if ((state_q == PAUSE) && step_now) begin
        digit_d     = wrap_inc(digit_q);
        step_pend_d = 1'b0;
      end else if (state_q == RUN) begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          digit_d = wrap_inc(digit_q);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end
    // A step requested while paused is dropped once RUN takes over.
    if ((state_q == PAUSE) && bus.run_en) step_pend_d = 1'b0;
  end

  always_ff @(posedge pix_clk or posedge reset) begin
    if (reset) begin
      state_q     <= PAUSE;
      vsync_q     <= 1'b1;
      armed_q     <= 1'b0;
      tick_q      <= 1'b0;
      digit_q     <= 4'd0;
      cnt_q       <= '0;
      load_pend_q <= 1'b0;
      step_pend_q <= 1'b0;
      ld_val_q    <= 4'd0;
    end else begin
      state_q     <= state_d;
      vsync_q     <= bus.vSync;
      armed_q     <= 1'b1;
      tick_q      <= fall;
      digit_q     <= digit_d;
      cnt_q       <= cnt_d;
      load_pend_q <= load_pend_d;
      step_pend_q <= step_pend_d;
      ld_val_q    <= ld_val_d;
    end
  end

  assign bus.digit      = digit_q;
  assign bus.running    = (state_q == RUN);
  assign bus.frame_tick = tick_q;
  assign bus.pending    = load_pend_q | step_pend_q;

endmodule

// File: tb/tb_digit_sequencer.sv
// Bench for digit_sequencer: directed scenarios plus random traffic, each cycle compared
// against a frame-level behavioural model of the sequencer.
module tb_digit_sequencer;
  localparam int FPS  = 3;
  localparam int MAXD = 9;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  digit_sequencer_if bus();

  digit_sequencer #(.FRAMES_PER_STEP(FPS), .MAX_DIGIT(MAXD)) dut (
    .pix_clk (clk),
    .reset   (rst),
    .bus     (bus)
  );

  int    total  = 0;
  int    passed = 0;
  string cur_tag = "reset";

  // model state: what the user-visible behaviour should be
  int m_digit, m_frames, m_ldv;
  bit m_run, m_lp, m_sp, m_tick, m_prev_vs, m_seen;
  bit vs_r, re_r;
  int ticks_seen;

  task automatic model_reset();
    m_digit = 0; m_frames = 0; m_ldv = 0;
    m_run = 0; m_lp = 0; m_sp = 0; m_tick = 0; m_prev_vs = 1; m_seen = 0;
  endtask

  task automatic model_update(input bit vs, input bit re, input bit st, input bit ld,
                              input int lv);
    bit frame_start;
    int clamped;
    clamped     = (lv > MAXD) ? MAXD : lv;
    frame_start = m_seen && m_prev_vs && !vs;
    if (frame_start) begin
      if (m_lp || ld) begin
        m_digit  = ld ? clamped : m_ldv;
        m_frames = 0; m_lp = 0; m_sp = 0;
      end else if (!m_run && (m_sp || (st && !m_run))) begin
        m_digit = (m_digit + 1) % (MAXD + 1);
        m_sp    = 0;
      end else if (m_run) begin
        m_frames = m_frames + 1;
        if (m_frames == FPS) begin
          m_frames = 0;
          m_digit  = (m_digit + 1) % (MAXD + 1);
        end
      end
    end else begin
      if (ld) begin m_lp = 1; m_ldv = clamped; end
      if (st && !m_run) m_sp = 1;
    end
    if (!m_run && re) m_sp = 0;
    m_run     = re;
    m_tick    = frame_start;
    m_prev_vs = vs;
    m_seen    = 1;
  endtask

  task automatic chk(input string name, input int obs, input int exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s/%s observed=%0d expected=%0d", cur_tag, name, obs, exp);
  endtask

  task automatic check_all();
    chk("digit",      int'(bus.digit),      m_digit);
    chk("running",    int'(bus.running),    int'(m_run));
    chk("frame_tick", int'(bus.frame_tick), int'(m_tick));
    chk("pending",    int'(bus.pending),    int'(m_lp | m_sp));
    if (bus.frame_tick === 1'b1) ticks_seen++;
  endtask

  task automatic cyc(input bit st, input bit ld, input int lv);
    bus.vSync    = vs_r;
    bus.run_en   = re_r;
    bus.step     = st;
    bus.load     = ld;
    bus.load_val = 4'(lv);
    @(posedge clk);
    #1;
    model_update(vs_r, re_r, st, ld, lv);
    check_all();
    bus.step = 1'b0;
    bus.load = 1'b0;
  endtask

  task automatic frame(input int hi, input int lo);
    vs_r = 1'b1;
    for (int i = 0; i < hi; i++) cyc(1'b0, 1'b0, 0);
    vs_r = 1'b0;
    for (int i = 0; i < lo; i++) cyc(1'b0, 1'b0, 0);
  endtask

  initial begin
    vs_r = 1'b1; re_r = 1'b0;
    bus.vSync = 1'b1; bus.run_en = 1'b0; bus.step = 1'b0;
    bus.load = 1'b0; bus.load_val = 4'd0;
    model_reset();
    #6;
    check_all();
    #2 rst = 1'b0;
    @(posedge clk); #1;

    // 1: three idle frames in PAUSE
    cur_tag = "t1"; ticks_seen = 0;
    for (int f = 0; f < 3; f++) frame(4, 3);
    chk("tick_count", ticks_seen, 3);
    chk("digit_idle", int'(bus.digit), 0);

    // 2: single step, then three steps within one frame
    cur_tag = "t2";
    vs_r = 1'b1;
    cyc(1'b0, 1'b0, 0); cyc(1'b1, 1'b0, 0);
    chk("pending_after_step", int'(bus.pending), 1);
    frame(2, 2);
    chk("digit_one_step", int'(bus.digit), 1);
    vs_r = 1'b1;
    cyc(1'b1, 1'b0, 0); cyc(1'b1, 1'b0, 0); cyc(1'b0, 1'b0, 0); cyc(1'b1, 1'b0, 0);
    frame(1, 2);
    chk("digit_multi_step", int'(bus.digit), 2);

    // 3: RUN from 8 with FPS=3
    cur_tag = "t3";
    vs_r = 1'b1; cyc(1'b0, 1'b1, 8);
    frame(2, 2);
    chk("digit_loaded8", int'(bus.digit), 8);
    re_r = 1'b1;
    for (int f = 1; f <= 9; f++) begin
      frame(3, 2);
      if (f == 3) chk("digit_tick3", int'(bus.digit), 9);
      if (f == 6) chk("digit_tick6", int'(bus.digit), 0);
      if (f == 9) chk("digit_tick9", int'(bus.digit), 1);
    end

    // 4: load mid-count in RUN restarts the count; out-of-range load clamps
    cur_tag = "t4";
    frame(3, 2); frame(3, 2);
    vs_r = 1'b1; cyc(1'b0, 1'b1, 4);
    frame(2, 2);
    chk("digit_load4", int'(bus.digit), 4);
    frame(3, 2); frame(3, 2);
    chk("digit_hold4", int'(bus.digit), 4);
    frame(3, 2);
    chk("digit_adv5", int'(bus.digit), 5);
    vs_r = 1'b1; cyc(1'b0, 1'b1, 12);
    frame(2, 2);
    chk("digit_clamp", int'(bus.digit), 9);

    // 5: load beats step; step on the fall cycle applies immediately
    cur_tag = "t5";
    re_r = 1'b0;
    frame(3, 2);
    vs_r = 1'b1;
    cyc(1'b0, 1'b1, 3); cyc(1'b1, 1'b0, 0);
    frame(1, 2);
    chk("digit_load_wins", int'(bus.digit), 3);
    chk("pending_cleared", int'(bus.pending), 0);
    vs_r = 1'b1; cyc(1'b0, 1'b0, 0); cyc(1'b0, 1'b0, 0);
    vs_r = 1'b0; cyc(1'b1, 1'b0, 0); cyc(1'b0, 1'b0, 0);
    chk("digit_same_cycle_step", int'(bus.digit), 4);

    // 6: asynchronous reset with a pending load, then vSync held low
    cur_tag = "t6";
    vs_r = 1'b1; cyc(1'b0, 1'b1, 5);
    frame(2, 2);
    re_r = 1'b1;
    vs_r = 1'b1; cyc(1'b0, 1'b0, 0); cyc(1'b0, 1'b1, 7);
    chk("pending_before_reset", int'(bus.pending), 1);
    chk("digit_before_reset", int'(bus.digit), 5);
    vs_r = 1'b0; re_r = 1'b0;
    bus.vSync = 1'b0; bus.run_en = 1'b0;
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all();
    #2 rst = 1'b0;
    ticks_seen = 0;
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 0);
    chk("no_tick_low_release", ticks_seen, 0);
    frame(2, 2);
    chk("tick_after_edge", ticks_seen, 1);

    // random traffic against the model
    cur_tag = "rand";
    for (int i = 0; i < 600; i++) begin
      bit st, ld;
      int lv;
      if ($urandom_range(0, 3) == 0) vs_r = ~vs_r;
      if ($urandom_range(0, 39) == 0) re_r = ~re_r;
      st = ($urandom_range(0, 9) == 0);
      ld = ($urandom_range(0, 14) == 0);
      lv = int'($urandom_range(0, 15));
      cyc(st, ld, lv);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
